// File: rtl/lsu_ctrl_if.sv
// EX/WB/MEM bundle for lsu_ctrl. The LSU connects to the slave modport.
// The environment (EX, WB and MEM) connects to the master modport.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 20
);
  // Handshakes on both req and resp complete on a rising edge where valid and ready are both high.
  // A sender holds valid and its payload stable until that edge.
  // A receiver may raise or lower ready freely.
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic [4:0]        resp_rd;
  logic              resp_wen;
  logic              resp_fault;
  logic [1:0]        resp_cause;

  logic              wen_MEM;
  logic [3:0]        lenoutmem;
  logic              suoutmem;
  logic [ADDR_W-1:0] ain_MEM;
  logic [63:0]       din_MEM;
  logic [63:0]       dout_MEM;

  modport slave (
    input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_wen, resp_fault, resp_cause,
    input  resp_ready,
    output wen_MEM, lenoutmem, suoutmem, ain_MEM, din_MEM,
    input  dout_MEM
  );

  modport master (
    output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_wen, resp_fault, resp_cause,
    output resp_ready,
    input  wen_MEM, lenoutmem, suoutmem, ain_MEM, din_MEM,
    output dout_MEM
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store front end: EX request -> one MEM ACCESS cycle -> tagged WB response.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as faults (cause 01).
module lsu_ctrl #(
  parameter int          ADDR_W    = 20,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [63:0]     off;
  logic [3:0]      size;
  logic [ADDR_W:0] last_byte;
  logic            is_mem;
  logic            illegal;
  logic            misaligned;
  logic            out_of_range;
  logic            fault;
  logic [1:0]      cause;
  logic            accept;

  logic              store_q;
  logic              capture_q;
  logic [3:0]        len_q;
  logic              su_q;
  logic [ADDR_W-1:0] ain_q;
  logic [63:0]       din_q;
  logic [4:0]        rd_q;
  logic              fault_q;
  logic [1:0]        cause_q;
  logic              resp_wen_q;
  logic [63:0]       rdata_q;

  // Request classification is evaluated straight from the EX inputs so the
  // accept edge can pick ACCESS or RESP without an extra cycle.
  always_comb begin
    off          = bus.req_addr - BASE_ADDR;
    size         = 4'd1 << bus.req_funct3[1:0];
    last_byte    = {1'b0, off[ADDR_W-1:0]} + (ADDR_W+1)'(size) - (ADDR_W+1)'(1);
    is_mem       = bus.req_load | bus.req_store;
    illegal      = (bus.req_load & bus.req_store)
                 | (bus.req_store & bus.req_funct3[2])
                 | (bus.req_load & (bus.req_funct3 == 3'b111));
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.req_funct3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      default: misaligned = |bus.req_addr[2:0];
    endcase
`else
    misaligned   = 1'b0;
`endif
    out_of_range = (off[63:ADDR_W] != '0) | last_byte[ADDR_W];
    fault        = illegal | (is_mem & (misaligned | out_of_range));
    cause        = 2'b00;
    if (illegal)                      cause = 2'b11;
    else if (is_mem & misaligned)     cause = 2'b01;
    else if (is_mem & out_of_range)   cause = 2'b10;
  end

  assign accept = (state_q == S_IDLE) & bus.req_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.req_valid) state_d = (fault | ~is_mem) ? S_RESP : S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (bus.resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q    <= 1'b0;
      capture_q  <= 1'b0;
      len_q      <= 4'b0000;
      su_q       <= 1'b0;
      ain_q      <= '0;
      din_q      <= 64'd0;
      rd_q       <= 5'd0;
      fault_q    <= 1'b0;
      cause_q    <= 2'b00;
      resp_wen_q <= 1'b0;
      rdata_q    <= 64'd0;
    end else if (accept) begin
      // Faulted requests never reach MEM, so their store/capture enables are cleared here.
      store_q    <= bus.req_store & ~fault;
      capture_q  <= bus.req_load & ~fault;
      len_q      <= size;
      su_q       <= ~bus.req_funct3[2];
      ain_q      <= off[ADDR_W-1:0];
      din_q      <= bus.req_wdata;
      rd_q       <= bus.req_rd;
      fault_q    <= fault;
      cause_q    <= cause;
      resp_wen_q <= bus.req_load & ~fault & (bus.req_rd != 5'd0);
      rdata_q    <= 64'd0;
    end else if ((state_q == S_ACCESS) && capture_q) begin
      rdata_q    <= bus.dout_MEM;
    end
  end

  // wen_MEM comes straight from the state register, so an async reset kills it at once.
  assign bus.wen_MEM    = (state_q == S_ACCESS) & store_q;
  assign bus.lenoutmem  = len_q;
  assign bus.suoutmem   = su_q;
  assign bus.ain_MEM    = ain_q;
  assign bus.din_MEM    = din_q;

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_rd    = rd_q;
  assign bus.resp_wen   = resp_wen_q;
  assign bus.resp_fault = fault_q;
  assign bus.resp_cause = cause_q;

  assign dbg_state_o    = state_q;

endmodule
